// File: rtl/col_parity_param.sv
// Parametrised column-parity engine: loads DEPTH pages of N x N bits,
// then re-streams them as theta-mixed pages or as bare column parities.
module col_parity_param #(
    parameter int N     = 5,
    parameter int DEPTH = 64,
    parameter int IDXW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [N*N-1:0]   in_data,
    output logic             ready,
    output logic [N*N-1:0]   out_data,
    output logic             done,
    output logic [IDXW-1:0]  page_index
);

    localparam int W  = N * N;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]   state;
    logic         mode_q;
    logic [N-1:0] par [DEPTH];

    logic [N-1:0] in_par;
    logic [N-1:0] cur_par;
    logic [N-1:0] prev_par;
    logic [AW-1:0] cur_idx;
    logic [AW-1:0] prev_idx;
    logic          last;
    logic [W-1:0]  theta;
    logic [W-1:0]  result;

    assign ready    = (state == S_IDLE);
    assign last     = (page_index == IDXW'(DEPTH - 1));
    assign cur_idx  = page_index[AW-1:0];
    // Page 0 mixes with the last page of the state.
    assign prev_idx = (cur_idx == '0) ? AW'(DEPTH - 1) : cur_idx - AW'(1);
    assign cur_par  = par[cur_idx];
    assign prev_par = par[prev_idx];

    always_comb begin
        in_par = '0;
        for (int x = 0; x < N; x++) begin
            for (int y = 0; y < N; y++) begin
                in_par[x] = in_par[x] ^ in_data[N*y + x];
            end
        end
    end

    always_comb begin
        theta = '0;
        for (int y = 0; y < N; y++) begin
            for (int x = 0; x < N; x++) begin
                theta[N*y + x] = in_data[N*y + x]
                               ^ cur_par[(x + N - 1) % N]
                               ^ prev_par[(x + 1) % N];
            end
        end
    end

    assign result = mode_q ? W'(cur_par) : theta;

    // Parity store is never cleared; LOAD rewrites every entry before use.
    always_ff @(posedge clk) begin
        if (!reset && state == S_LOAD) begin
            par[cur_idx] <= in_par;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            done       <= 1'b0;
            out_data   <= '0;
            page_index <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done       <= 1'b0;
                    page_index <= '0;
                    if (start) begin
                        mode_q <= mode;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (last) begin
                        page_index <= '0;
                        state      <= S_EMIT;
                    end else begin
                        page_index <= page_index + IDXW'(1);
                    end
                end
                S_EMIT: begin
                    out_data <= result;
                    done     <= 1'b1;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    done <= 1'b0;
                    if (last) begin
                        page_index <= '0;
                        state      <= S_IDLE;
                    end else begin
                        page_index <= page_index + IDXW'(1);
                        state      <= S_EMIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_col_parity_param.sv
// Bench for col_parity_param: vector table, random runs against a
// parity model, reset abort, held start, and a small N=3/DEPTH=8 build.
module tb_col_parity_param;

    localparam int N = 5;
    localparam int D = 64;
    localparam int W = N * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic [W-1:0]  in_data;
    logic [W-1:0]  out_data;
    logic          ready;
    logic          done;
    logic [5:0]    page_index;
    logic [W-1:0]  mem [D];
    logic [W-1:0]  exp_pages [D];

    logic          s_start;
    logic          s_mode;
    logic [8:0]    s_in;
    logic [8:0]    s_out;
    logic          s_ready;
    logic          s_done;
    logic [2:0]    s_idx;
    logic [8:0]    smem [8];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign in_data = mem[page_index];
    assign s_in    = smem[s_idx];

    col_parity_param #(.N(5), .DEPTH(64), .IDXW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in_data(in_data), .ready(ready), .out_data(out_data),
        .done(done), .page_index(page_index)
    );

    col_parity_param #(.N(3), .DEPTH(8), .IDXW(3)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .mode(s_mode),
        .in_data(s_in), .ready(s_ready), .out_data(s_out),
        .done(s_done), .page_index(s_idx)
    );

    typedef struct {
        int          pg;
        logic [24:0] val;
        logic        m;
        int          e0;
        logic [24:0] v0;
        int          e1;
        logic [24:0] v1;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic bit col_par(int x, int z);
        bit p = 1'b0;
        for (int y = 0; y < N; y++) p ^= mem[z][N*y + x];
        return p;
    endfunction

    function automatic logic [W-1:0] model_page(int z, logic m);
        logic [W-1:0] r = '0;
        if (m) begin
            for (int x = 0; x < N; x++) r[x] = col_par(x, z);
        end else begin
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++)
                    r[N*y + x] = mem[z][N*y + x]
                               ^ col_par((x + N - 1) % N, z)
                               ^ col_par((x + 1) % N, (z + D - 1) % D);
        end
        return r;
    endfunction

    // Runs one pass; hold = cycles start stays high, abort_at > 0 stops
    // after that many done pulses without waiting for ready.
    task automatic run_big(input logic m, input int hold, input int abort_at,
                           input string tag);
        int  c;
        int  k = 0;
        int  ready_cyc = -1;
        bit  prev_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        c = hold - 1;
        if (hold == 1) check({tag, "_ready_low"}, ready, 0);
        while (c < 4 * D) begin
            @(negedge clk);
            c++;
            if (done) begin
                check({tag, "_done_gap"}, prev_done, 0);
                check({tag, "_done_time"}, c, D + 1 + 2 * k);
                check({tag, "_page"}, out_data, exp_pages[k]);
                k++;
                if (abort_at > 0 && k == abort_at) return;
            end
            prev_done = done;
            if (ready) begin
                ready_cyc = c;
                break;
            end
        end
        check({tag, "_ready_cyc"}, ready_cyc, 3 * D);
        check({tag, "_done_cnt"}, k, D);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        s_start = 1'b0;
        s_mode  = 1'b0;
        for (int i = 0; i < D; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) smem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_out", out_data, 0);
        check("rst_idx", page_index, 0);
        reset = 1'b0;

        vecs[0] = '{-1, 25'h0, 1'b0, -1, 25'h0, -1, 25'h0};
        vecs[1] = '{0, 25'h1, 1'b0, 0, 25'h0210843, 1, 25'h1084210};
        vecs[2] = '{63, 25'h1, 1'b0, 63, 25'h0210843, 0, 25'h1084210};
        vecs[3] = '{5, 25'h1FFFFFF, 1'b1, 5, 25'h000001F, -1, 25'h0};
        vecs[4] = '{0, 25'h1, 1'b1, 0, 25'h0000001, -1, 25'h0};

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < D; i++) begin
                mem[i] = '0;
                exp_pages[i] = '0;
            end
            if (vecs[v].pg >= 0) mem[vecs[v].pg] = vecs[v].val;
            if (vecs[v].e0 >= 0) exp_pages[vecs[v].e0] = vecs[v].v0;
            if (vecs[v].e1 >= 0) exp_pages[vecs[v].e1] = vecs[v].v1;
            run_big(vecs[v].m, 1, 0, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 3; r++) begin
            logic rm;
            rm = 1'($urandom_range(0, 1));
            for (int i = 0; i < D; i++) mem[i] = W'($urandom);
            for (int i = 0; i < D; i++) exp_pages[i] = model_page(i, rm);
            run_big(rm, 1, 0, $sformatf("rnd%0d", r));
        end

        for (int i = 0; i < D; i++) mem[i] = W'($urandom);
        for (int i = 0; i < D; i++) exp_pages[i] = model_page(i, 1'b0);
        run_big(1'b0, 1, 10, "abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_out", out_data, 0);
        check("abort_idx", page_index, 0);
        reset = 1'b0;

        for (int i = 0; i < D; i++) begin
            mem[i] = '0;
            exp_pages[i] = '0;
        end
        mem[0] = 25'h1;
        exp_pages[0] = 25'h0210843;
        exp_pages[1] = 25'h1084210;
        run_big(1'b0, 3, 0, "held");
        begin
            int extra = 0;
            repeat (2 * D) begin
                @(negedge clk);
                if (done || !ready) extra++;
            end
            check("held_single_run", extra, 0);
        end

        begin
            int c = 0;
            int k = 0;
            int rc = -1;
            logic [8:0] sexp [8];
            for (int i = 0; i < 8; i++) sexp[i] = '0;
            sexp[0] = 9'h093;
            sexp[1] = 9'h124;
            smem[0] = 9'h001;
            @(negedge clk);
            s_start = 1'b1;
            s_mode  = 1'b0;
            @(negedge clk);
            s_start = 1'b0;
            while (c < 40) begin
                @(negedge clk);
                c++;
                if (s_done) begin
                    check("small_page", s_out, sexp[k & 7]);
                    k++;
                end
                if (s_ready) begin
                    rc = c;
                    break;
                end
            end
            check("small_ready_cyc", rc, 24);
            check("small_done_cnt", k, 8);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/col_parity_param.md
# col_parity_param

Parametrised column-parity engine, the successor to the fixed 5x5x64 column-parity block. It streams a state of DEPTH pages, each an N x N bit slice, from an external page memory addressed by `page_index`. It computes per-column parities and re-streams the pages out with `done` strobes. Two modes are supported: full theta mixing, or parity-only output. It sits between the page-memory front end and the downstream permutation stages.

## Interface
Parameters:
- `N`, 5: slice dimension; page width W = N*N.
- `DEPTH`, 64: pages per state; must be ≥ 2.
- `IDXW`, 6: `page_index` width; must be ≥ $clog2(DEPTH).

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  level; sampled only in IDLE.
- `mode`  in  1  0 = theta, 1 = parity-only; latched when start is accepted.
- `in_data`  in  W  page at `page_index`; external memory is combinational, valid same cycle.
- `ready`  out  1  high exactly in IDLE (decoded from state).
- `out_data`  out  W  registered result page.
- `done`  out  1  registered one-cycle strobe, one per output page.
- `page_index`  out  IDXW  registered page address.

## Operation
- Bit map: page bit i = N*y + x, with x = column 0..N-1 and y = row 0..N-1.
- Column parity: C[x][z] = XOR over y of page z bit (N*y+x). Store as a DEPTH x N register array.
- Theta (`mode`=0): out[z](x,y) = in[z](x,y) ^ C[(x-1) mod N][z] ^ C[(x+1) mod N][(z-1) mod DEPTH].
  - Both wraps are mandatory: column x = 0 uses column N-1, and page 0 uses page DEPTH-1.
- Parity-only (`mode`=1): out[z] bit x = C[x][z] for x < N; all higher bits are 0.
- States:
  - IDLE: `ready`=1, `page_index`=0. If `start`=1, latch `mode` and go to LOAD.
  - LOAD: store C[*][page_index] from `in_data`.
    - If `page_index`=DEPTH-1: set `page_index` to 0 and go to EMIT.
    - Otherwise increment `page_index`.
  - EMIT: register `out_data` from `in_data` and C, set `done` to 1, go to HOLD.
  - HOLD: set `done` to 0.
    - If `page_index`=DEPTH-1: set `page_index` to 0 and go to IDLE.
    - Otherwise increment `page_index` and go to EMIT.
- `start` is ignored outside IDLE. If `start` is still high on return to IDLE, a new run begins on the next edge.
- The memory is re-read during the EMIT phase. It must not change between LOAD and the end of EMIT.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `out_data`=0, `page_index`=0, latched mode=0.
  - The C array is not cleared; LOAD fully overwrites it before use.
- Reset has priority over every state. Asserting `reset` mid-run aborts the run at the next edge with the reset values above.
- Let edge 0 be the edge that accepts `start`:
  - LOAD occupies edges 1..DEPTH.
  - The `done` for page k rises after edge DEPTH+1+2k and falls after edge DEPTH+2+2k.
  - `out_data` holds until the next EMIT.
  - After edge 3*DEPTH: IDLE, `ready`=1.
  - Total run length is 3*DEPTH cycles; `done` is never high on two consecutive cycles.
- Output pages are emitted strictly in order 0..DEPTH-1, with exactly DEPTH `done` pulses per run.

## Test plan
- All-zero state, `mode`=0 -> 64 `done` pulses, every `out_data`=0, `ready` returns after 192 cycles.
- Page 0 = 0x0000001, all other pages 0, `mode`=0 -> out[0]=0x0210843, out[1]=0x1084210, all other pages 0.
- Wrap-around: page 63 = 0x0000001, all other pages 0, `mode`=0 -> out[63]=0x0210843, out[0]=0x1084210, all other pages 0.
- Parity-only: page 5 = 0x1FFFFFF, all other pages 0, `mode`=1 -> out[5]=0x000001F, all other pages 0.
- Reset after the 10th `done` pulse -> next edge gives `ready`=1, `done`=0, `out_data`=0, `page_index`=0. A restarted run with the page 0 = 0x0000001 stimulus reproduces that scenario's outputs exactly; `start` held high for 3 cycles triggers exactly one run.
- N=3, DEPTH=8, page 0 = 0x001, `mode`=0 -> out[0]=0x093 (bits 0,1,4,7), out[1]=0x124 (bits 2,5,8), all other pages 0; total run length 24 cycles.
